// File: rtl/wave_pkg.sv
// Shared state encoding and payload framing constants for the waveform transmit path.
package wave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE,
        GAP
    } tx_state_t;

    localparam int HDR_LEN = 2;

    // Header byte 0 carries the top five frequency bits, byte 1 the low eight.
    function automatic logic [7:0] hdr_byte(input logic [12:0] f, input logic idx);
        return idx ? f[7:0] : {3'b000, f[12:8]};
    endfunction

endpackage

// File: rtl/wave_tx_ctrl.sv
// Frames FIFO samples behind a 2-byte frequency header and paces UDP transmits.
// Latency: tx_start_en 1 cycle after the IDLE->START decision; each byte 1 cycle after its tx_req.
// Backpressure: bytes move only on tx_req; waits for tx_done (bounded by DONE_TIMEOUT), then idles GAP_CYCLES.
module wave_tx_ctrl
    import wave_pkg::*;
#(
    parameter int          PKT_LEN      = 1024,
    parameter int          GAP_CYCLES   = 125,
    parameter logic [15:0] DONE_TIMEOUT = 16'd20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [12:0] freq,
    input  logic [12:0] rd_data_count,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [15:0] pkt_cnt,
    output logic        tx_err
);

    localparam logic [15:0] TOTAL    = 16'(PKT_LEN + HDR_LEN);
    localparam logic [15:0] HDR      = 16'(HDR_LEN);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = DONE_TIMEOUT - 16'd1;

    tx_state_t   state, state_nxt;
    logic [15:0] byte_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] to_cnt;
    logic [12:0] freq_l;
    logic [7:0]  hdr_q;
    logic        fifo_sel_q;
    logic        req_ok;

    assign req_ok      = (state == SEND) && tx_req && (byte_cnt < TOTAL);
    assign fifo_rd_en  = req_ok && (byte_cnt >= HDR);
    assign tx_start_en = (state == START);
    assign tx_byte_num = TOTAL;
    // FIFO data arrives one cycle after the strobe, so it is muxed after the register.
    assign tx_data     = fifo_sel_q ? fifo_dout : hdr_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && ({3'b000, rd_data_count} >= 16'(PKT_LEN)))
                    state_nxt = START;
            end
            START: state_nxt = SEND;
            SEND: begin
                if (tx_done)
                    state_nxt = GAP;
                else if (req_ok && (byte_cnt == TOTAL - 16'd1))
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done || (to_cnt == TO_LAST))
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            freq_l     <= '0;
            pkt_cnt    <= '0;
            tx_err     <= 1'b0;
            hdr_q      <= '0;
            fifo_sel_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            hdr_q      <= '0;
            fifo_sel_q <= 1'b0;

            if ((state == IDLE) && (state_nxt == START))
                freq_l <= freq;

            if (state == START) begin
                byte_cnt <= '0;
            end else if (req_ok) begin
                byte_cnt <= byte_cnt + 16'd1;
                if (byte_cnt < HDR)
                    hdr_q <= hdr_byte(freq_l, byte_cnt[0]);
                else
                    fifo_sel_q <= 1'b1;
            end

            // Both counters restart from zero on every entry to their state.
            to_cnt  <= (state == WAIT_DONE) ? to_cnt + 16'd1 : 16'd0;
            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

            if (((state == SEND) || (state == WAIT_DONE)) && tx_done)
                pkt_cnt <= pkt_cnt + 16'd1;

            if ((state == WAIT_DONE) && !tx_done && (to_cnt == TO_LAST))
                tx_err <= 1'b1;
        end
    end

endmodule
